// File: rtl/riscv_pkg.sv
// Shared definitions for the multicycle RV32I core: opcode constants,
// FSM state encoding, trap-cause codes, immediate formats and the
// immediate generator used by the decoder.
package riscv_pkg;

    localparam logic [6:0] OP     = 7'b0110011;
    localparam logic [6:0] OP_IMM = 7'b0010011;
    localparam logic [6:0] LOAD   = 7'b0000011;
    localparam logic [6:0] STORE  = 7'b0100011;
    localparam logic [6:0] BRANCH = 7'b1100011;
    localparam logic [6:0] JAL    = 7'b1101111;
    localparam logic [6:0] JALR   = 7'b1100111;
    localparam logic [6:0] LUI    = 7'b0110111;
    localparam logic [6:0] AUIPC  = 7'b0010111;
    localparam logic [6:0] SYSTEM = 7'b1110011;

    typedef enum logic [2:0] {
        S_FETCH_ISSUE,
        S_FETCH_WAIT,
        S_EXEC,
        S_MEM_WAIT,
        S_HALT
    } state_e;

    typedef enum logic [1:0] {
        CAUSE_NONE         = 2'd0,
        CAUSE_ILLEGAL      = 2'd1,
        CAUSE_MISALIGN_LS  = 2'd2,
        CAUSE_MISALIGN_JMP = 2'd3
    } cause_e;

    typedef enum logic [2:0] {IMM_I, IMM_S, IMM_B, IMM_U, IMM_J} imm_fmt_e;

    function automatic logic [31:0] imm_gen(input logic [31:0] ins, input imm_fmt_e fmt);
        case (fmt)
            IMM_I:   return {{20{ins[31]}}, ins[31:20]};
            IMM_S:   return {{20{ins[31]}}, ins[31:25], ins[11:7]};
            IMM_B:   return {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
            IMM_U:   return {ins[31:12], 12'b0};
            default: return {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
        endcase
    endfunction

endpackage

// File: rtl/riscv_rv32i_mc_cpu_if.sv
// Bus bundle between the core and the SoC interconnect.
//   i_*  : instruction fetch, req/ready handshake
//   d_*  : data access (byte enables, VRAM flag), req/ready handshake
//   io_* : CSR-over-I/O strobes (active-low) for peripheral CSRs
// master = core side, slave = interconnect side.
interface riscv_rv32i_mc_cpu_if;
    logic        i_req;
    logic [31:0] i_addr;
    logic [31:0] i_rdata;
    logic        i_ready;
    logic        d_req;
    logic [3:0]  d_we;
    logic        d_vram;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic [31:0] d_rdata;
    logic        d_ready;
    logic        io_rdn;
    logic        io_wrn;
    logic [11:0] io_addr;
    logic [31:0] io_wdata;
    logic [31:0] io_rdata;

    modport master (
        output i_req, i_addr, input i_rdata, i_ready,
        output d_req, d_we, d_vram, d_addr, d_wdata, input d_rdata, d_ready,
        output io_rdn, io_wrn, io_addr, io_wdata, input io_rdata
    );

    modport slave (
        input i_req, i_addr, output i_rdata, i_ready,
        input d_req, d_we, d_vram, d_addr, d_wdata, output d_rdata, d_ready,
        input io_rdn, io_wrn, io_addr, io_wdata, output io_rdata
    );
endinterface

// File: rtl/riscv_regfile.sv
// Architectural register file.
//   clk            : write clock
//   ra1/ra2, rd1/rd2 : two asynchronous read ports
//   we/wa/wd       : one synchronous write port
// x0 has no storage and always reads 0; indices >= NREGS also read 0.
module riscv_regfile #(
    parameter int NREGS = 32
) (
    input  logic        clk,
    input  logic [4:0]  ra1,
    input  logic [4:0]  ra2,
    output logic [31:0] rd1,
    output logic [31:0] rd2,
    input  logic        we,
    input  logic [4:0]  wa,
    input  logic [31:0] wd
);
    logic [31:0] rf [1:NREGS-1];

    always_ff @(posedge clk) begin
        for (int i = 1; i < NREGS; i++)
            if (we && wa == 5'(i)) rf[i] <= wd;
    end

    always_comb begin
        rd1 = '0;
        rd2 = '0;
        for (int i = 1; i < NREGS; i++) begin
            if (ra1 == 5'(i)) rd1 = rf[i];
            if (ra2 == 5'(i)) rd2 = rf[i];
        end
    end
endmodule

// File: rtl/riscv_rv32i_mc_cpu.sv
// Multicycle RV32I/RV32E core with req/ready instruction and data ports,
// CSRRW mapped onto an I/O strobe port, and a sticky trap/halt.
//   clk, clrn         : clock, async active-low reset
//   bus (master)      : i_*, d_*, io_* handshakes (all outputs registered)
//   trap/trap_pc/trap_cause : sticky fault report
module riscv_rv32i_mc_cpu
    import riscv_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          NREGS    = 32,
    parameter logic [2:0]  VRAM_TAG = 3'b110,
    parameter bit          EN_CSRRW = 1'b1
) (
    input  logic                 clk,
    input  logic                 clrn,
    riscv_rv32i_mc_cpu_if.master bus,
    output logic                 trap,
    output logic [31:0]          trap_pc,
    output logic [1:0]           trap_cause
);
    state_e      state, state_nxt;
    logic [31:0] pc, ir, inst;
    logic [6:0]  opc, f7;
    logic [4:0]  rd, rs1, rs2;
    logic [2:0]  f3;
    imm_fmt_e    fmt;
    logic        illegal, bad_reg, ill, use_rd, use_rs1, use_rs2;
    logic        is_load, is_store, is_csr, is_mem;
    logic [31:0] rs1_v, rs2_v, imm, ea, alu_b, alu_y, tgt, wb_exec, ld_word, ld_data, st_data;
    logic [3:0]  st_we;
    logic        take, jump, mis_ls, fault, rf_we;
    logic [31:0] rf_wd;
    cause_e      cause;

    // registered outputs and their next values
    logic        i_req_q, d_req_q, d_vram_q, io_rdn_q, io_wrn_q, trap_q;
    logic        i_req_n, d_req_n, d_vram_n, io_rdn_n, io_wrn_n, trap_n;
    logic [3:0]  d_we_q, d_we_n;
    logic [31:0] d_addr_q, d_addr_n, d_wdata_q, d_wdata_n, io_wdata_q, io_wdata_n;
    logic [31:0] trap_pc_q, trap_pc_n;
    logic [11:0] io_addr_q, io_addr_n;
    logic [1:0]  cause_q, cause_n;

    // Decode the word being latched on the fetch-completion edge so the
    // CSR strobes can be registered and still be low during EXEC itself.
    assign inst = (state == S_FETCH_WAIT && bus.i_ready) ? bus.i_rdata : ir;
    assign opc  = inst[6:0];
    assign rd   = inst[11:7];
    assign f3   = inst[14:12];
    assign rs1  = inst[19:15];
    assign rs2  = inst[24:20];
    assign f7   = inst[31:25];

    riscv_regfile #(.NREGS(NREGS)) u_rf (
        .clk(clk), .ra1(rs1), .ra2(rs2), .rd1(rs1_v), .rd2(rs2_v),
        .we(rf_we), .wa(rd), .wd(rf_wd)
    );

    always_comb begin
        fmt = IMM_I; illegal = 1'b0;
        use_rd = 1'b0; use_rs1 = 1'b0; use_rs2 = 1'b0;
        is_load = 1'b0; is_store = 1'b0; is_csr = 1'b0;
        case (opc)
            LUI, AUIPC: begin fmt = IMM_U; use_rd = 1'b1; end
            JAL:        begin fmt = IMM_J; use_rd = 1'b1; end
            JALR:       begin use_rd = 1'b1; use_rs1 = 1'b1; illegal = (f3 != 3'b000); end
            BRANCH: begin
                fmt = IMM_B; use_rs1 = 1'b1; use_rs2 = 1'b1;
                illegal = (f3[2:1] == 2'b01);
            end
            LOAD: begin
                use_rd = 1'b1; use_rs1 = 1'b1; is_load = 1'b1;
                illegal = (f3 == 3'b011) || (f3[2:1] == 2'b11);
            end
            STORE: begin
                fmt = IMM_S; use_rs1 = 1'b1; use_rs2 = 1'b1; is_store = 1'b1;
                illegal = f3[2] || (f3[1:0] == 2'b11);
            end
            OP_IMM: begin
                use_rd = 1'b1; use_rs1 = 1'b1;
                illegal = (f3 == 3'b001 && f7 != 7'b0) ||
                          (f3 == 3'b101 && f7 != 7'b0 && f7 != 7'b0100000);
            end
            OP: begin
                use_rd = 1'b1; use_rs1 = 1'b1; use_rs2 = 1'b1;
                illegal = !(f7 == 7'b0 || (f7 == 7'b0100000 && (f3 == 3'b000 || f3 == 3'b101)));
            end
            SYSTEM: begin
                if (EN_CSRRW && f3 == 3'b001) begin
                    is_csr = 1'b1; use_rd = 1'b1; use_rs1 = 1'b1;
                end else begin
                    illegal = 1'b1;
                end
            end
            default: illegal = 1'b1;
        endcase
    end

    assign bad_reg = (use_rd && int'(rd) >= NREGS) || (use_rs1 && int'(rs1) >= NREGS) ||
                     (use_rs2 && int'(rs2) >= NREGS);
    assign ill     = illegal || bad_reg;
    assign is_mem  = is_load || is_store;
    assign imm     = imm_gen(inst, fmt);
    assign ea      = rs1_v + imm;
    assign mis_ls  = is_mem && ((f3[1:0] == 2'b01 && ea[0]) ||
                                (f3[1:0] == 2'b10 && ea[1:0] != 2'b00));

    always_comb begin
        alu_b = (opc == OP) ? rs2_v : imm;
        case (f3)
            3'b000:  alu_y = (opc == OP && f7[5]) ? rs1_v - alu_b : rs1_v + alu_b;
            3'b001:  alu_y = rs1_v << alu_b[4:0];
            3'b010:  alu_y = {31'b0, $signed(rs1_v) < $signed(alu_b)};
            3'b011:  alu_y = {31'b0, rs1_v < alu_b};
            3'b100:  alu_y = rs1_v ^ alu_b;
            3'b101:  alu_y = f7[5] ? $unsigned($signed(rs1_v) >>> alu_b[4:0]) : rs1_v >> alu_b[4:0];
            3'b110:  alu_y = rs1_v | alu_b;
            default: alu_y = rs1_v & alu_b;
        endcase
    end

    always_comb begin
        case (f3)
            3'b000:  take = (rs1_v == rs2_v);
            3'b001:  take = (rs1_v != rs2_v);
            3'b100:  take = ($signed(rs1_v) < $signed(rs2_v));
            3'b101:  take = !($signed(rs1_v) < $signed(rs2_v));
            3'b110:  take = (rs1_v < rs2_v);
            default: take = !(rs1_v < rs2_v);
        endcase
    end

    always_comb begin
        wb_exec = alu_y;
        tgt     = pc + imm;
        jump    = 1'b0;
        case (opc)
            LUI:    wb_exec = imm;
            AUIPC:  wb_exec = pc + imm;
            JAL:    begin wb_exec = pc + 32'd4; jump = 1'b1; end
            JALR:   begin wb_exec = pc + 32'd4; tgt = ea & ~32'd1; jump = 1'b1; end
            BRANCH: jump = take;
            SYSTEM: wb_exec = bus.io_rdata;
            default: ;
        endcase
    end

    always_comb begin
        if (ill)                  cause = CAUSE_ILLEGAL;
        else if (mis_ls)          cause = CAUSE_MISALIGN_LS;
        else if (jump && tgt[1])  cause = CAUSE_MISALIGN_JMP;
        else                      cause = CAUSE_NONE;
    end
    assign fault = (cause != CAUSE_NONE);

    // load lane extraction and store lane replication
    assign ld_word = bus.d_rdata >> {ea[1:0], 3'b000};
    always_comb begin
        case (f3)
            3'b000:  ld_data = {{24{ld_word[7]}}, ld_word[7:0]};
            3'b001:  ld_data = {{16{ld_word[15]}}, ld_word[15:0]};
            3'b100:  ld_data = {24'b0, ld_word[7:0]};
            3'b101:  ld_data = {16'b0, ld_word[15:0]};
            default: ld_data = ld_word;
        endcase
        case (f3[1:0])
            2'b00:   begin st_we = 4'b0001 << ea[1:0];        st_data = {4{rs2_v[7:0]}};  end
            2'b01:   begin st_we = 4'b0011 << {ea[1], 1'b0};  st_data = {2{rs2_v[15:0]}}; end
            default: begin st_we = 4'b1111;                   st_data = rs2_v;            end
        endcase
        if (is_load) st_we = 4'b0000;
    end

    assign rf_we = (state == S_EXEC && !fault && !is_mem && use_rd) ||
                   (state == S_MEM_WAIT && bus.d_ready && is_load);
    assign rf_wd = (state == S_MEM_WAIT) ? ld_data : wb_exec;

    // FSM: state register
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) state <= S_FETCH_ISSUE;
        else       state <= state_nxt;
    end

    // FSM: next state
    always_comb begin
        state_nxt = state;
        case (state)
            S_FETCH_ISSUE: state_nxt = S_FETCH_WAIT;
            S_FETCH_WAIT:  if (bus.i_ready) state_nxt = S_EXEC;
            S_EXEC:        state_nxt = fault ? S_HALT : (is_mem ? S_MEM_WAIT : S_FETCH_ISSUE);
            S_MEM_WAIT:    if (bus.d_ready) state_nxt = S_FETCH_ISSUE;
            default:       state_nxt = S_HALT;
        endcase
    end

    // FSM: outputs (next values, registered below)
    always_comb begin
        i_req_n    = (state_nxt == S_FETCH_WAIT);
        d_req_n    = (state_nxt == S_MEM_WAIT);
        d_we_n     = d_we_q;
        d_vram_n   = d_vram_q;
        d_addr_n   = d_addr_q;
        d_wdata_n  = d_wdata_q;
        io_rdn_n   = !(state_nxt == S_EXEC && is_csr && !ill && rd  != 5'd0);
        io_wrn_n   = !(state_nxt == S_EXEC && is_csr && !ill && rs1 != 5'd0);
        io_addr_n  = io_addr_q;
        io_wdata_n = io_wdata_q;
        trap_n     = (state_nxt == S_HALT);
        trap_pc_n  = trap_pc_q;
        cause_n    = cause_q;
        if (state == S_EXEC && state_nxt == S_MEM_WAIT) begin
            d_we_n    = st_we;
            d_vram_n  = (ea[31:29] == VRAM_TAG);
            d_addr_n  = {ea[31:2], 2'b00};
            d_wdata_n = st_data;
        end else if (state == S_MEM_WAIT && bus.d_ready) begin
            d_we_n = 4'b0000;
        end
        if (state_nxt == S_EXEC && is_csr) begin
            io_addr_n  = inst[31:20];
            io_wdata_n = rs1_v;
        end
        if (state == S_EXEC && fault) begin
            trap_pc_n = pc;
            cause_n   = cause;
        end
    end

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            pc <= RESET_PC; ir <= '0;
            i_req_q <= 1'b0; d_req_q <= 1'b0; d_we_q <= '0; d_vram_q <= 1'b0;
            d_addr_q <= '0; d_wdata_q <= '0;
            io_rdn_q <= 1'b1; io_wrn_q <= 1'b1; io_addr_q <= '0; io_wdata_q <= '0;
            trap_q <= 1'b0; trap_pc_q <= '0; cause_q <= CAUSE_NONE;
        end else begin
            i_req_q <= i_req_n; d_req_q <= d_req_n; d_we_q <= d_we_n; d_vram_q <= d_vram_n;
            d_addr_q <= d_addr_n; d_wdata_q <= d_wdata_n;
            io_rdn_q <= io_rdn_n; io_wrn_q <= io_wrn_n; io_addr_q <= io_addr_n; io_wdata_q <= io_wdata_n;
            trap_q <= trap_n; trap_pc_q <= trap_pc_n; cause_q <= cause_n;
            if (state == S_FETCH_WAIT && bus.i_ready) ir <= bus.i_rdata;
            if (state == S_EXEC && !fault && !is_mem) pc <= jump ? tgt : pc + 32'd4;
            else if (state == S_MEM_WAIT && bus.d_ready) pc <= pc + 32'd4;
        end
    end

    // i_addr tracks pc directly; pc only moves while no fetch is pending
    assign bus.i_req    = i_req_q;
    assign bus.i_addr   = pc;
    assign bus.d_req    = d_req_q;
    assign bus.d_we     = d_we_q;
    assign bus.d_vram   = d_vram_q;
    assign bus.d_addr   = d_addr_q;
    assign bus.d_wdata  = d_wdata_q;
    assign bus.io_rdn   = io_rdn_q;
    assign bus.io_wrn   = io_wrn_q;
    assign bus.io_addr  = io_addr_q;
    assign bus.io_wdata = io_wdata_q;
    assign trap         = trap_q;
    assign trap_pc      = trap_pc_q;
    assign trap_cause   = cause_q;
endmodule

// File: doc/riscv_rv32i_mc_cpu.md
Name: riscv_rv32i_mc_cpu

Overview:
Multicycle RV32I core with request/ready handshakes on separate instruction and data ports, so it tolerates variable-latency memories and wait states.
- Parametrised in reset vector, register count (RV32I/RV32E) and VRAM window.
- Adds illegal/misaligned trapping with a sticky halt.
- Keeps the CSRRW-over-I/O path (io_rdn/io_wrn) for the SoC's peripheral CSRs.
- Sits between the SoC interconnect (imem, dmem, VRAM, I/O) and nothing else.

Parameters:
RESET_PC, 32'h0000_0000, pc loaded at reset
NREGS, 32, architectural registers; 32 = RV32I, 16 = RV32E (rs/rt/rd bit 4 set -> illegal)
VRAM_TAG, 3'b110, data address bits [31:29] selecting VRAM space
EN_CSRRW, 1, 1 = decode CSRRW onto the I/O port, 0 = CSRRW is illegal

Ports:
clk  in  1  clock
clrn  in  1  reset, asynchronous, active-low
i_req  out  1  instruction fetch request
i_addr  out  32  fetch address (= pc)
i_rdata  in  32  fetched instruction
i_ready  in  1  fetch data valid / accepted
d_req  out  1  data access request
d_we  out  4  byte write enables (0 = read)
d_vram  out  1  access targets VRAM window
d_addr  out  32  data address, word-aligned
d_wdata  out  32  store data, byte-lane aligned
d_rdata  in  32  load data (word)
d_ready  in  1  data access complete
io_rdn  out  1  CSR/I-O read strobe, active-low
io_wrn  out  1  CSR/I-O write strobe, active-low
io_addr  out  12  CSR number
io_wdata  out  32  CSR write data
io_rdata  in  32  CSR read data
trap  out  1  sticky: core halted on fault
trap_pc  out  32  pc of faulting instruction
trap_cause  out  2  1 illegal, 2 misaligned load/store, 3 misaligned jump target

Behaviour:
- Asynchronous reset (clrn low):
  - state = FETCH_ISSUE, pc = RESET_PC, i_req = 0, d_req = 0, d_we = 0, d_vram = 0, io_rdn = 1, io_wrn = 1, trap = 0, trap_pc = 0, trap_cause = 0.
  - Register file is not reset; x0 reads 0 always.
- All handshake outputs are registered.
- States: FETCH_ISSUE, FETCH_WAIT, EXEC, MEM_WAIT, HALT.
- FETCH_ISSUE: raise i_req, i_addr = pc; go to FETCH_WAIT.
- FETCH_WAIT: hold i_req/i_addr stable. On i_ready: latch i_rdata into the instruction register, drop i_req, go to EXEC.
- EXEC (one cycle): decode, read regs, execute.
  - ALU/LUI/AUIPC/JAL/JALR/branch: write rd, update pc, go to FETCH_ISSUE.
  - Load/store: latch d_addr/d_we/d_wdata/d_vram, raise d_req, go to MEM_WAIT.
  - CSRRW (EN_CSRRW = 1): io_rdn low if rd != 0, io_wrn low if rs1 != 0, for exactly this cycle. io_rdata is captured into rd at the end of EXEC.
- MEM_WAIT: hold d_* stable. On d_ready: drop d_req; for loads, extract the byte/half with zero/sign extension by address bits [1:0] and write rd; pc += 4; go to FETCH_ISSUE.
- Cycles per instruction at zero wait (i_ready/d_ready high the first cycle of req): 3 for ALU/branch/jump/CSRRW, 4 for load/store. Each wait cycle adds 1.
- Stores:
  - SB: d_we = 4'b0001 << a[1:0], byte replicated on all lanes.
  - SH: d_we = 4'b0011 << {a[1],0}, half replicated.
  - SW: d_we = 4'b1111.
  - d_addr = {a[31:2], 2'b00}.
- Misaligned access (LH/LHU/SH with a[0] = 1; LW/SW with a[1:0] != 0) or jump/taken-branch target with bit 1 set: no bus access, no rd write, go to HALT.
- Illegal encoding (unknown opcode/func3/func7, register index >= NREGS) also goes to HALT.
- HALT: trap = 1, trap_pc = pc, trap_cause set; all requests low. Only reset exits HALT.
- SLT/SLTU/SLTI/SLTIU write rd (0 or 1); JALR target = (rs1 + imm) & ~1.
- Writes to x0 are discarded.
- d_vram = (effective address [31:29] == VRAM_TAG).
- Reset asserted mid-handshake: requests drop asynchronously; no partial register write.

Decomposition:
- Package riscv_pkg holds:
  - opcode constants (OP, OP_IMM, LOAD, STORE, BRANCH, JAL, JALR, LUI, AUIPC, SYSTEM);
  - state enum;
  - trap-cause codes;
  - immediate-format enum (I/S/B/U/J).
- One sub-module, riscv_regfile: parameter NREGS, two async read ports, one sync write port, x0 hard zero.

Test Plan:
- Reset with RESET_PC = 32'h100, i_ready tied 1 -> first i_addr = 32'h100 with i_req high one cycle after clrn rises; i_addr = 32'h104 three cycles later.
- addi x1,x0,5; addi x2,x0,-3; add x3,x1,x2; slt x4,x2,x1 -> x3 = 2, x4 = 1; repeat with i_ready delayed 2 cycles -> same results, 5 cycles per instruction.
- x5 = 32'hC000_0003; sb x1,0(x5) -> d_vram = 1, d_addr = 32'hC000_0000, d_we = 4'b1000, d_wdata = 32'h0505_0505.
- d_rdata = 32'h80FF_7F01 at 32'h200; lb/lbu at 0x203 and lh at 0x202 -> lb = 32'hFFFF_FF80, lbu = 32'h0000_0080, lh = 32'hFFFF_80FF.
- lw from 32'h201 -> d_req never rises, trap = 1, trap_cause = 2, trap_pc = pc of lw; all outputs frozen until reset.
- NREGS = 16, add x17,x1,x2 -> trap_cause = 1; csrrw x1,0x7C0,x2 with x2 = 9, io_rdata = 32'hAA -> io_wrn/io_rdn low one cycle, io_addr = 12'h7C0, io_wdata = 9, x1 = 32'hAA.
